// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and an external
// loader/debug master. CPU owns by default; EXT gets bounded bursts; both sides starvation-guarded.
//
// state | meaning
// S_CPU | CPU is default owner; EXT served when CPU idle or when EXT has starved
// S_EXT | EXT burst in progress; CPU stalled until the burst ends or the CPU starves
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    input  logic          ext_last,
    output logic          ext_gnt,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {S_CPU = 1'b0, S_EXT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [SW-1:0] ext_wait, ext_wait_nxt;
    logic [SW-1:0] cpu_wait, cpu_wait_nxt;
    logic          cpu_serve, ext_serve;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CPU;
            beat_cnt <= '0;
            ext_wait <= '0;
            cpu_wait <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            ext_wait <= ext_wait_nxt;
            cpu_wait <= cpu_wait_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        ext_wait_nxt = ext_wait;
        cpu_wait_nxt = cpu_wait;
        cpu_serve    = 1'b0;
        ext_serve    = 1'b0;
        case (state)
            S_CPU: begin
                if (ext_req && ext_wait == STARVE_MAX) begin
                    ext_serve = 1'b1;
                end else begin
                    cpu_serve = cpu_req;
                    ext_serve = ext_req && !cpu_req;
                end
                if (ext_serve || !ext_req)
                    ext_wait_nxt = '0;
                else if (ext_wait != STARVE_MAX)
                    ext_wait_nxt = ext_wait + 1'b1;
                if (ext_serve && !ext_last && MAX_BURST > 1) begin
                    state_nxt    = S_EXT;
                    beat_cnt_nxt = BW'(1);
                end
            end
            S_EXT: begin
                if (cpu_req && cpu_wait == STARVE_MAX) begin
                    cpu_serve = 1'b1;
                    state_nxt = S_CPU;
                end else if (!ext_req) begin
                    // abandoned burst: no beat, CPU gets the cycle
                    cpu_serve = cpu_req;
                    state_nxt = S_CPU;
                end else begin
                    ext_serve = 1'b1;
                    if (beat_cnt != BURST_MAX)
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    if (cpu_req && cpu_wait != STARVE_MAX)
                        cpu_wait_nxt = cpu_wait + 1'b1;
                    if (ext_last || beat_cnt == BURST_LAST)
                        state_nxt = S_CPU;
                end
                if (state_nxt == S_CPU) begin
                    beat_cnt_nxt = '0;
                    cpu_wait_nxt = '0;
                    ext_wait_nxt = '0;
                end
            end
            default: state_nxt = S_CPU;
        endcase
    end

    // reset blocks every grant and write in the same cycle it is asserted
    assign ext_gnt   = ext_serve && !reset;
    assign cpu_stall = cpu_req && !cpu_serve && !reset;
    assign mem_we    = !reset && (ext_serve ? ext_we : (cpu_serve && cpu_we));
    assign mem_addr  = ext_serve ? ext_addr  : cpu_addr;
    assign mem_wdata = ext_serve ? ext_wdata : cpu_wdata;
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario bench for dmem_arbiter with a behavioural datamem and
// per-port scoreboards of expected served accesses.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we, ext_last;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, ext_gnt, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t ext_q[$];
    acc_t cpu_q[$];

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_last(ext_last), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    // scoreboard: pop the expected access for whichever port is served this cycle
    always @(negedge clk) begin
        acc_t e;
        #2;
        if (!reset && ext_gnt) begin
            n_checks++;
            if (ext_q.size() == 0) begin
                n_errors++;
                $display("FAIL ext_unexpected_gnt: addr=%h with no beat outstanding", mem_addr);
            end else begin
                e = ext_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we ||
                    (e.we && mem_wdata !== e.data) || (!e.we && ext_rdata !== e.data)) begin
                    n_errors++;
                    $display("FAIL ext_beat: got we=%b addr=%h wdata=%h rdata=%h, expected we=%b addr=%h data=%h",
                             mem_we, mem_addr, mem_wdata, ext_rdata, e.we, e.addr, e.data);
                end
            end
        end
        if (!reset && cpu_req && !cpu_stall && !ext_gnt) begin
            n_checks++;
            if (cpu_q.size() == 0) begin
                n_errors++;
                $display("FAIL cpu_unexpected_serve: addr=%h with no access outstanding", mem_addr);
            end else begin
                e = cpu_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we ||
                    (e.we && mem_wdata !== e.data) || (!e.we && cpu_rdata !== e.data)) begin
                    n_errors++;
                    $display("FAIL cpu_access: got we=%b addr=%h wdata=%h rdata=%h, expected we=%b addr=%h data=%h",
                             mem_we, mem_addr, mem_wdata, cpu_rdata, e.we, e.addr, e.data);
                end
            end
        end
    end

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_last = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h11;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h24; ext_wdata = 32'h22;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_override: got we=%b gnt=%b stall=%b, expected 0 0 0", mem_we, ext_gnt, cpu_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        n_checks++;
        if (dut.state !== 1'b0 || mem[8] !== 32'h0 || mem[9] !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: got state=%b mem8=%h mem9=%h, expected 0 0 0", dut.state, mem[8], mem[9]);
        end
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
        cpu_q.push_back('{1'b1, 32'h10, 32'hA5});
        #1;
        n_checks++;
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0 || ext_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL cpu_write: got we=%b stall=%b gnt=%b, expected 1 0 0", mem_we, cpu_stall, ext_gnt);
        end
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_q.push_back('{1'b0, 32'h10, 32'hA5});
        #1;
        n_checks++;
        if (mem[4] !== 32'hA5 || cpu_rdata !== 32'hA5) begin
            n_errors++;
            $display("FAIL cpu_readback: got mem=%h rdata=%h, expected a5", mem[4], cpu_rdata);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_ext_burst4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'(4 * i);
            ext_wdata = 32'h100 + 32'(i); ext_last = (i == 3);
            ext_q.push_back('{1'b1, 32'(4 * i), 32'h100 + 32'(i)});
            #1;
            n_checks++;
            if (ext_gnt !== 1'b1 || (i == 1 && dut.state !== 1'b1)) begin
                n_errors++;
                $display("FAIL burst4_beat%0d: got gnt=%b state=%b, expected gnt=1", i, ext_gnt, dut.state);
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (dut.state !== 1'b0 || dut.beat_cnt !== '0 || mem[0] !== 32'h100 || mem[3] !== 32'h103) begin
            n_errors++;
            $display("FAIL burst4_end: got state=%b cnt=%0d mem0=%h mem3=%h, expected 0 0 100 103",
                     dut.state, dut.beat_cnt, mem[0], mem[3]);
        end
    endtask

    task automatic test_ext_read();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'(4 * i); ext_last = (i == 1);
            ext_q.push_back('{1'b0, 32'(4 * i), 32'h100 + 32'(i)});
            #1;
            n_checks++;
            if (ext_gnt !== 1'b1 || mem_we !== 1'b0) begin
                n_errors++;
                $display("FAIL ext_read%0d: got gnt=%b we=%b, expected 1 0", i, ext_gnt, mem_we);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_ext_burst12();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40 + 32'(4 * i);
            ext_wdata = 32'h200 + 32'(i); ext_last = (i == 11);
            ext_q.push_back('{1'b1, 32'h40 + 32'(4 * i), 32'h200 + 32'(i)});
            #1;
            n_checks++;
            if (ext_gnt !== 1'b1 || (i == 7 && dut.state !== 1'b1) || (i == 8 && dut.state !== 1'b0)
                || (i == 9 && dut.state !== 1'b1)) begin
                n_errors++;
                $display("FAIL burst12_beat%0d: got gnt=%b state=%b", i, ext_gnt, dut.state);
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (dut.state !== 1'b0 || mem[16] !== 32'h200 || mem[23] !== 32'h207 || mem[24] !== 32'h208
            || mem[27] !== 32'h20B) begin
            n_errors++;
            $display("FAIL burst12_end: got state=%b mem16=%h mem23=%h mem24=%h mem27=%h",
                     dut.state, mem[16], mem[23], mem[24], mem[27]);
        end
    endtask

    task automatic test_cpu_preempt();
        int  j = 0;
        logic pushed = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80 + 32'(4 * j);
            ext_wdata = 32'h300 + 32'(j); ext_last = (c == 6);
            if (!pushed) begin
                ext_q.push_back('{1'b1, 32'h80 + 32'(4 * j), 32'h300 + 32'(j)});
                pushed = 1'b1;
            end
            cpu_req = (c >= 1 && c <= 5); cpu_we = 1'b1; cpu_addr = 32'hF0; cpu_wdata = 32'hC4;
            if (c == 1) cpu_q.push_back('{1'b1, 32'hF0, 32'hC4});
            #1;
            n_checks++;
            if (ext_gnt !== (c != 5) || cpu_stall !== (c >= 1 && c <= 4) ||
                (c == 5 && (mem_we !== 1'b1 || mem_addr !== 32'hF0))) begin
                n_errors++;
                $display("FAIL preempt_c%0d: got gnt=%b stall=%b we=%b addr=%h, expected gnt=%b stall=%b",
                         c, ext_gnt, cpu_stall, mem_we, mem_addr, (c != 5), (c >= 1 && c <= 4));
            end
            if (ext_gnt) begin
                j++;
                pushed = 1'b0;
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (mem[60] !== 32'hC4 || mem[37] !== 32'h305 || dut.state !== 1'b0) begin
            n_errors++;
            $display("FAIL preempt_end: got cpu_mem=%h last_ext=%h state=%b, expected c4 305 0",
                     mem[60], mem[37], dut.state);
        end
    endtask

    task automatic test_ext_starve();
        logic cpu_pending = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
            if (!cpu_pending) begin
                cpu_q.push_back('{1'b0, 32'h10, 32'hA5});
                cpu_pending = 1'b1;
            end
            ext_req = (c <= 4); ext_we = 1'b1; ext_addr = 32'hE0; ext_wdata = 32'h5A5A; ext_last = 1'b1;
            if (c == 0) ext_q.push_back('{1'b1, 32'hE0, 32'h5A5A});
            #1;
            n_checks++;
            if (ext_gnt !== (c == 4) || cpu_stall !== (c == 4) ||
                (c == 4 && (mem_we !== 1'b1 || mem_addr !== 32'hE0))) begin
                n_errors++;
                $display("FAIL starve_c%0d: got gnt=%b stall=%b we=%b addr=%h, expected gnt=%b stall=%b",
                         c, ext_gnt, cpu_stall, mem_we, mem_addr, (c == 4), (c == 4));
            end
            if (cpu_req && !cpu_stall) cpu_pending = 1'b0;
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (mem[56] !== 32'h5A5A || dut.state !== 1'b0) begin
            n_errors++;
            $display("FAIL starve_end: got mem=%h state=%b, expected 5a5a 0", mem[56], dut.state);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset = (c == 2);
            ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'hA0 + 32'(4 * c);
            ext_wdata = (c == 2) ? 32'hDEAD : 32'h400 + 32'(c); ext_last = 1'b0;
            if (c < 2) ext_q.push_back('{1'b1, 32'hA0 + 32'(4 * c), 32'h400 + 32'(c)});
            #1;
            n_checks++;
            if ((c < 2 && ext_gnt !== 1'b1) || (c == 2 && (mem_we !== 1'b0 || ext_gnt !== 1'b0))) begin
                n_errors++;
                $display("FAIL rst_burst_c%0d: got gnt=%b we=%b", c, ext_gnt, mem_we);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        n_checks++;
        if (dut.state !== 1'b0 || dut.beat_cnt !== '0 || dut.cpu_wait !== '0 || dut.ext_wait !== '0
            || mem[42] !== 32'h0 || mem[41] !== 32'h401) begin
            n_errors++;
            $display("FAIL rst_burst_end: got state=%b cnt=%0d cw=%0d ew=%0d mem42=%h mem41=%h, expected 0 0 0 0 0 401",
                     dut.state, dut.beat_cnt, dut.cpu_wait, dut.ext_wait, mem[42], mem[41]);
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        #3;
        n_checks++;
        if (ext_q.size() != 0 || cpu_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got ext=%0d cpu=%0d outstanding, expected 0 0",
                     ext_q.size(), cpu_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_cpu_write();
        test_ext_burst4();
        test_ext_read();
        test_ext_burst12();
        test_cpu_preempt();
        test_ext_starve();
        test_reset_mid_burst();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
